// File: rtl/btn_pulse_bank.sv
// rtl/btn_pulse_bank.sv - N-channel button synchroniser, debouncer and edge/auto-repeat pulse generator
module btn_pulse_bank #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int REP_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bi,
  input  logic [1:0]   mode,
  output logic [N-1:0] bo,
  output logic [N-1:0] level,
  output logic         any_pulse
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_N  = DW'(DEB_CYCLES);
  localparam logic [RW-1:0] HOLD_N = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_N  = RW'(REP_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic press_en;
  logic rel_en;
  logic rep_en;

  assign press_en = (mode != 2'b01);
  assign rel_en   = (mode == 2'b01) || (mode == 2'b10);
  assign rep_en   = (mode == 2'b11);

  logic [N-1:0] pulse_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q;
    logic                   lvl_q;
    logic                   s;
    state_t                 st_q;
    state_t                 st_d;
    logic [RW-1:0]          rc_q;
    logic [RW-1:0]          rc_d;
    logic [RW-1:0]          rc_inc;
    logic                   pulse;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        dcnt_q <= '0;
        lvl_q  <= 1'b0;
        st_q   <= IDLE;
        rc_q   <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bi[i]};
        if (s == lvl_q) begin
          dcnt_q <= '0;
        end else if (dcnt_q + DW'(1) == DEB_N) begin
          lvl_q  <= ~lvl_q;
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_q + DW'(1);
        end
        st_q <= st_d;
        rc_q <= rc_d;
      end
    end

    // Saturating increment keeps the repeat counter from wrapping.
    assign rc_inc = (rc_q == {RW{1'b1}}) ? rc_q : rc_q + RW'(1);

    always_comb begin
      st_d  = st_q;
      rc_d  = rc_q;
      pulse = 1'b0;
      case (st_q)
        IDLE: begin
          rc_d = '0;
          if (lvl_q) begin
            st_d  = HELD;
            pulse = press_en;
          end
        end
        HELD: begin
          if (!lvl_q) begin
            st_d  = IDLE;
            rc_d  = '0;
            pulse = rel_en;
          end else if (rep_en) begin
            if (rc_inc == HOLD_N) begin
              st_d  = REPEAT;
              rc_d  = '0;
              pulse = 1'b1;
            end else begin
              rc_d = rc_inc;
            end
          end else begin
            rc_d = '0;
          end
        end
        REPEAT: begin
          // Release wins over a coincident repeat match.
          if (!lvl_q) begin
            st_d  = IDLE;
            rc_d  = '0;
            pulse = rel_en;
          end else if (!rep_en) begin
            st_d = HELD;
            rc_d = '0;
          end else if (rc_inc == REP_N) begin
            rc_d  = '0;
            pulse = 1'b1;
          end else begin
            rc_d = rc_inc;
          end
        end
        default: begin
          st_d = IDLE;
          rc_d = '0;
        end
      endcase
    end

    assign pulse_d[i] = pulse;
    assign level[i]   = lvl_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bo        <= '0;
      any_pulse <= 1'b0;
    end else begin
      bo        <= pulse_d;
      any_pulse <= |pulse_d;
    end
  end

endmodule
